adder_pipe_nbit: RTL and testbench
==================================

Name: adder_pipe_nbit

Overview:
Parametrised, pipelined add/subtract unit that generalises the team's 4-bit ripple adder to WIDTH bits. The carry chain is cut into SLICE-bit segments, with one segment per pipeline stage, and the block reports signed overflow. Upstream and downstream connect through valid/ready handshakes, with full backpressure. The block sits in datapaths that need throughput of one operation per cycle at widths where a single ripple chain misses timing.

Parameters:
WIDTH, 16, operand and result width in bits; must be a multiple of SLICE, and at least SLICE.
SLICE, 4, bits added per pipeline stage; STAGES = WIDTH/SLICE, which is also the latency in cycles.

Ports:
clk  input  1  clock; all state on the rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operation presented on a, b, cin, sub.
in_ready  output  1  block accepts the operation this cycle.
a  input  WIDTH  operand A, unsigned or two's complement.
b  input  WIDTH  operand B.
cin  input  1  carry-in (add) or borrow-in (subtract).
sub  input  1  0: a+b+cin; 1: a-b-cin.
out_valid  output  1  result present.
out_ready  input  1  downstream accepts the result.
sum  output  WIDTH  result, modulo 2^WIDTH.
cout  output  1  add: carry-out; subtract: 1 means no borrow.
ovf  output  1  signed two's-complement overflow.

Behaviour:
- Reset: asserting rst_n low immediately clears every stage-valid bit, all data registers, out_valid, sum, cout and ovf to 0; in_ready reads 1 after reset.
- Reset mid-operation: all in-flight operations are discarded; nothing is emitted after release.
- Operand conditioning at accept: b_eff = sub ? ~b : b; c_eff = sub ? ~cin : cin.
- Stage k (0..STAGES-1): adds slice k of a and b_eff plus the carry registered from stage k-1 (c_eff for stage 0), then registers the SLICE-bit result and carry-out.
- Skew registers: unconsumed upper slices of a and b_eff move forward with the operation; completed lower result slices are delayed so the full sum emerges aligned.
- Final stage sets cout = carry out of the MSB, and ovf = carry into MSB XOR carry out of MSB.
- Transfer rules: an input transfer occurs when in_valid && in_ready; an output transfer occurs when out_valid && out_ready.
- Global stall: advance = !out_valid || out_ready. Every stage register updates only when advance is 1; in_ready = advance.
- Bubbles are allowed: a stage whose valid bit is 0 carries no data, and bubbles are not compressed.
- Latency: an operation accepted in cycle t appears with out_valid in cycle t+STAGES when no stall occurs. Throughput is 1 op/cycle.
- Backpressure: while out_valid && !out_ready, sum/cout/ovf hold stable and in_ready is 0. No operation is lost or reordered.
- Simultaneous accept and emit in the same cycle is legal and required for full throughput.
- Inputs are sampled only on accept; changes while in_ready is 0 have no effect.
- Wrap-around: the sum is modulo 2^WIDTH; the carry and overflow flags carry the extra information.
- Degenerate case WIDTH == SLICE: a single stage with latency 1, functionally a registered version of the 4-bit adder.

Decomposition:
- Package adder_pkg: default WIDTH/SLICE constants, and an operation struct {a, b, cin, sub} plus a result struct {sum, cout, ovf} for reuse by the bench.
- One sub-module, adder_slice: a purely combinational SLICE-bit ripple adder (a, b, ci -> s, co, c_msb_in), instantiated STAGES times via generate.
- Stage registers and skew shifting stay in the top module.

Test Plan:
- WIDTH=16, SLICE=4: a=0x0000, b=0x0000, cin=0, sub=0 -> 4 cycles later sum=0x0000, cout=0, ovf=0.
- a=0xFFFF, b=0x0001, add -> sum=0x0000, cout=1, ovf=0; a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
- Subtract: a=0x0005, b=0x0007, cin=0, sub=1 -> sum=0xFFFE, cout=0, ovf=0; a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
- Stream 8 back-to-back ops, holding out_ready low for 3 cycles mid-stream -> in_ready low during the stall, outputs held stable, all 8 results correct and in order.
- WIDTH=4, SLICE=4: a=1010, b=0110, cin=1 -> sum=0001, cout=1, one cycle later; a=1010, b=1010, cin=0 -> sum=0100, cout=1.
- Assert rst_n for 1 cycle with 3 ops in flight -> out_valid=0 and all outputs 0 immediately, no stale result afterwards; the next accepted op completes after STAGES cycles.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared constants and operation/result records for the pipelined adder.
package adder_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_SLICE = 4;

    typedef struct packed {
        logic [DEF_WIDTH-1:0] a;
        logic [DEF_WIDTH-1:0] b;
        logic                 cin;
        logic                 sub;
    } add_op_t;

    typedef struct packed {
        logic [DEF_WIDTH-1:0] sum;
        logic                 cout;
        logic                 ovf;
    } add_res_t;

endpackage

// File: rtl/adder_slice.sv
// Combinational SLICE-bit ripple adder; one instance per pipeline stage.
module adder_slice
    import adder_pkg::*;
#(
    parameter int SLICE = DEF_SLICE
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             ci,
    output logic [SLICE-1:0] s,
    output logic             co,
    output logic             c_msb_in
);

    // Ripple the carry through the slice; c_msb_in feeds the overflow flag.
    always_comb begin : p_ripple
        logic [SLICE:0] c;
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < SLICE; i++) begin
            s[i]     = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        co       = c[SLICE];
        c_msb_in = c[SLICE-1];
    end

endmodule

// File: rtl/adder_pipe_nbit.sv
// WIDTH-bit add/subtract unit, carry chain cut into SLICE-bit pipeline stages,
// valid/ready on both sides with a single global stall.
module adder_pipe_nbit
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = WIDTH / SLICE;

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Subtraction as a + ~b + ~borrow; cin doubles as borrow-in.
    assign b_eff = sub ? ~b : b;
    assign c_eff = sub ? ~cin : cin;

    // Each stage's acc register starts as operand a and has one finished result
    // slice shifted in from the top per stage, so after the last stage it holds
    // the aligned sum.  The b register shrinks by one slice per stage, keeping
    // only the operand bits not yet consumed.
    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int BIN = WIDTH - k * SLICE;

        logic             v_in;
        logic             c_in;
        logic [WIDTH-1:0] acc_in;
        logic [BIN-1:0]   b_in;
        logic [SLICE-1:0] s;
        logic             co;
        logic [WIDTH-1:0] acc_d;
        logic             v_q;
        logic             c_q;
        logic [WIDTH-1:0] acc_q;

        if (k == 0) begin : g_src
            assign v_in   = in_valid;
            assign c_in   = c_eff;
            assign acc_in = a;
            assign b_in   = b_eff;
        end else begin : g_src
            assign v_in   = g_st[k-1].v_q;
            assign c_in   = g_st[k-1].c_q;
            assign acc_in = g_st[k-1].acc_q;
            assign b_in   = g_st[k-1].g_bn.b_q;
        end

        if (STAGES == 1) begin : g_acc
            assign acc_d = s;
        end else begin : g_acc
            assign acc_d = {s, acc_in[WIDTH-1:SLICE]};
        end

        if (k == STAGES - 1) begin : g_fin
            logic c_msb;
            logic ovf_q;

            adder_slice #(.SLICE(SLICE)) u_slice (
                .a        (acc_in[SLICE-1:0]),
                .b        (b_in[SLICE-1:0]),
                .ci       (c_in),
                .s        (s),
                .co       (co),
                .c_msb_in (c_msb)
            );

            // Signed overflow: carry into the MSB disagrees with carry out of it.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (advance && v_in) begin
                    ovf_q <= c_msb ^ co;
                end
            end
        end else begin : g_mid
            logic c_msb_unused;

            adder_slice #(.SLICE(SLICE)) u_slice (
                .a        (acc_in[SLICE-1:0]),
                .b        (b_in[SLICE-1:0]),
                .ci       (c_in),
                .s        (s),
                .co       (co),
                .c_msb_in (c_msb_unused)
            );
        end

        if (k < STAGES - 1) begin : g_bn
            logic [BIN-SLICE-1:0] b_q;

            // Carry the not-yet-added upper slices of b forward with the operation.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    b_q <= '0;
                end else if (advance && v_in) begin
                    b_q <= b_in[BIN-1:SLICE];
                end
            end
        end

        // Stage register: valid moves with every advance (bubbles included);
        // data loads only for real operations so outputs hold the last result.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q   <= 1'b0;
                c_q   <= 1'b0;
                acc_q <= '0;
            end else if (advance) begin
                v_q <= v_in;
                if (v_in) begin
                    c_q   <= co;
                    acc_q <= acc_d;
                end
            end
        end
    end

    assign out_valid = g_st[STAGES-1].v_q;
    assign sum       = g_st[STAGES-1].acc_q;
    assign cout      = g_st[STAGES-1].c_q;
    assign ovf       = g_st[STAGES-1].g_fin.ovf_q;

endmodule

// File: tb/tb_adder_pipe_nbit.sv
// Directed bench for the pipelined adder: 16-bit/4-slice and 4-bit/4-slice builds.
module tb_adder_pipe_nbit;
    import adder_pkg::*;

    logic        clk;
    logic        rst_n;

    logic        in_valid16, in_ready16, cin16, sub16;
    logic        out_valid16, out_ready16, cout16, ovf16;
    logic [15:0] a16, b16, sum16;

    logic        in_valid4, in_ready4, cin4, sub4;
    logic        out_valid4, out_ready4, cout4, ovf4;
    logic [3:0]  a4, b4, sum4;

    int total = 0;
    int bad   = 0;

    add_op_t  ops [8];
    add_res_t exps[8];

    adder_pipe_nbit #(.WIDTH(16), .SLICE(4)) u_dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .a         (a16),
        .b         (b16),
        .cin       (cin16),
        .sub       (sub16),
        .out_valid (out_valid16),
        .out_ready (out_ready16),
        .sum       (sum16),
        .cout      (cout16),
        .ovf       (ovf16)
    );

    adder_pipe_nbit #(.WIDTH(4), .SLICE(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .a         (a4),
        .b         (b4),
        .cin       (cin4),
        .sub       (sub4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .sum       (sum4),
        .cout      (cout4),
        .ovf       (ovf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One isolated operation on the 16-bit unit: checks exact 4-cycle latency.
    task automatic run16(input string tag, input add_op_t op, input add_res_t r);
        @(negedge clk);
        a16 = op.a; b16 = op.b; cin16 = op.cin; sub16 = op.sub; in_valid16 = 1'b1;
        @(negedge clk);
        in_valid16 = 1'b0;
        repeat (2) @(negedge clk);
        chk({tag, "_early"}, 32'(out_valid16), 32'd0);
        @(negedge clk);
        chk({tag, "_valid"}, 32'(out_valid16), 32'd1);
        chk({tag, "_sum"},   32'(sum16),       32'(r.sum));
        chk({tag, "_cout"},  32'(cout16),      32'(r.cout));
        chk({tag, "_ovf"},   32'(ovf16),       32'(r.ovf));
    endtask

    initial begin
        int tx, rx, stall_cnt;

        rst_n = 1'b0;
        in_valid16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0; out_ready16 = 1'b1;
        in_valid4  = 1'b0; a4  = '0; b4  = '0; cin4  = 1'b0; sub4  = 1'b0; out_ready4  = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid16), 32'd0);
        chk("rst_sum",       32'(sum16),       32'd0);
        chk("rst_cout",      32'(cout16),      32'd0);
        chk("rst_ovf",       32'(ovf16),       32'd0);
        chk("rst_in_ready",  32'(in_ready16),  32'd1);
        chk("rst_out_valid4",32'(out_valid4),  32'd0);
        rst_n = 1'b1;

        run16("zero",     '{a:16'h0000, b:16'h0000, cin:1'b0, sub:1'b0}, '{sum:16'h0000, cout:1'b0, ovf:1'b0});
        run16("wrap",     '{a:16'hFFFF, b:16'h0001, cin:1'b0, sub:1'b0}, '{sum:16'h0000, cout:1'b1, ovf:1'b0});
        run16("pos_ovf",  '{a:16'h7FFF, b:16'h0001, cin:1'b0, sub:1'b0}, '{sum:16'h8000, cout:1'b0, ovf:1'b1});
        run16("sub_neg",  '{a:16'h0005, b:16'h0007, cin:1'b0, sub:1'b1}, '{sum:16'hFFFE, cout:1'b0, ovf:1'b0});
        run16("sub_ovf",  '{a:16'h8000, b:16'h0001, cin:1'b0, sub:1'b1}, '{sum:16'h7FFF, cout:1'b1, ovf:1'b1});
        run16("xslice",   '{a:16'h0FFF, b:16'h0001, cin:1'b1, sub:1'b0}, '{sum:16'h1001, cout:1'b0, ovf:1'b0});
        run16("borrowin", '{a:16'h1234, b:16'h0234, cin:1'b1, sub:1'b1}, '{sum:16'h0FFF, cout:1'b1, ovf:1'b0});

        // Back-to-back stream with out_ready low for three cycles.
        ops[0] = '{a:16'h0001, b:16'h0002, cin:1'b0, sub:1'b0}; exps[0] = '{sum:16'h0003, cout:1'b0, ovf:1'b0};
        ops[1] = '{a:16'h1234, b:16'h4321, cin:1'b0, sub:1'b0}; exps[1] = '{sum:16'h5555, cout:1'b0, ovf:1'b0};
        ops[2] = '{a:16'hFFFF, b:16'hFFFF, cin:1'b1, sub:1'b0}; exps[2] = '{sum:16'hFFFF, cout:1'b1, ovf:1'b0};
        ops[3] = '{a:16'h8000, b:16'h8000, cin:1'b0, sub:1'b0}; exps[3] = '{sum:16'h0000, cout:1'b1, ovf:1'b1};
        ops[4] = '{a:16'h0010, b:16'h0001, cin:1'b0, sub:1'b1}; exps[4] = '{sum:16'h000F, cout:1'b1, ovf:1'b0};
        ops[5] = '{a:16'h0000, b:16'h0001, cin:1'b0, sub:1'b1}; exps[5] = '{sum:16'hFFFF, cout:1'b0, ovf:1'b0};
        ops[6] = '{a:16'h7FFF, b:16'hFFFF, cin:1'b0, sub:1'b1}; exps[6] = '{sum:16'h8000, cout:1'b0, ovf:1'b1};
        ops[7] = '{a:16'hABCD, b:16'h1111, cin:1'b1, sub:1'b0}; exps[7] = '{sum:16'hBCDF, cout:1'b0, ovf:1'b0};

        tx = 0; rx = 0; stall_cnt = 0;
        for (int cyc = 0; cyc < 60 && rx < 8; cyc++) begin
            @(negedge clk);
            out_ready16 = !(cyc >= 5 && cyc <= 7);
            in_valid16  = (tx < 8);
            if (tx < 8) begin
                a16 = ops[tx].a; b16 = ops[tx].b; cin16 = ops[tx].cin; sub16 = ops[tx].sub;
            end
            #1;
            if (out_valid16 && !out_ready16) begin
                stall_cnt++;
                chk("stall_in_ready", 32'(in_ready16), 32'd0);
                chk("stall_hold_sum", 32'(sum16),      32'(exps[rx].sum));
            end
            if (out_valid16 && out_ready16) begin
                chk($sformatf("stream%0d_sum", rx),  32'(sum16),  32'(exps[rx].sum));
                chk($sformatf("stream%0d_cout", rx), 32'(cout16), 32'(exps[rx].cout));
                chk($sformatf("stream%0d_ovf", rx),  32'(ovf16),  32'(exps[rx].ovf));
                rx++;
            end
            if (in_valid16 && in_ready16) tx++;
        end
        in_valid16  = 1'b0;
        out_ready16 = 1'b1;
        chk("stream_count", 32'(rx),        32'd8);
        chk("stream_stall", 32'(stall_cnt), 32'd3);

        // Degenerate single-stage build.
        @(negedge clk);
        a4 = 4'b1010; b4 = 4'b0110; cin4 = 1'b1; sub4 = 1'b0; in_valid4 = 1'b1;
        @(negedge clk);
        in_valid4 = 1'b0;
        chk("w4_a_valid", 32'(out_valid4), 32'd1);
        chk("w4_a_sum",   32'(sum4),       32'h1);
        chk("w4_a_cout",  32'(cout4),      32'd1);
        chk("w4_a_ovf",   32'(ovf4),       32'd0);
        @(negedge clk);
        a4 = 4'b1010; b4 = 4'b1010; cin4 = 1'b0; sub4 = 1'b0; in_valid4 = 1'b1;
        @(negedge clk);
        in_valid4 = 1'b0;
        chk("w4_b_valid", 32'(out_valid4), 32'd1);
        chk("w4_b_sum",   32'(sum4),       32'h4);
        chk("w4_b_cout",  32'(cout4),      32'd1);
        chk("w4_b_ovf",   32'(ovf4),       32'd1);
        @(negedge clk);
        chk("w4_idle_valid", 32'(out_valid4), 32'd0);
        a4 = 4'b0011; b4 = 4'b0101; cin4 = 1'b0; sub4 = 1'b1; in_valid4 = 1'b1;
        @(negedge clk);
        in_valid4 = 1'b0;
        chk("w4_sub_sum",  32'(sum4),  32'hE);
        chk("w4_sub_cout", 32'(cout4), 32'd0);
        chk("w4_sub_ovf",  32'(ovf4),  32'd0);

        // Reset with three operations still in flight behind a valid output.
        @(negedge clk);
        in_valid16 = 1'b1; a16 = 16'h8000; b16 = 16'hFFFF; cin16 = 1'b0; sub16 = 1'b0;
        @(negedge clk);
        a16 = 16'h0001; b16 = 16'h0001;
        @(negedge clk);
        a16 = 16'h0002; b16 = 16'h0002;
        @(negedge clk);
        a16 = 16'h0003; b16 = 16'h0003;
        @(negedge clk);
        in_valid16 = 1'b0;
        #1;
        chk("prerst_valid", 32'(out_valid16), 32'd1);
        chk("prerst_sum",   32'(sum16),       32'h7FFF);
        chk("prerst_cout",  32'(cout16),      32'd1);
        chk("prerst_ovf",   32'(ovf16),       32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid",    32'(out_valid16), 32'd0);
        chk("midrst_sum",      32'(sum16),       32'd0);
        chk("midrst_cout",     32'(cout16),      32'd0);
        chk("midrst_ovf",      32'(ovf16),       32'd0);
        chk("midrst_in_ready", 32'(in_ready16),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("no_stale%0d", i), 32'(out_valid16), 32'd0);
        end
        run16("post_rst", '{a:16'h0F0F, b:16'h00F1, cin:1'b0, sub:1'b0}, '{sum:16'h1000, cout:1'b0, ovf:1'b0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
